// File: rtl/data_mem_unit_if.sv
// Request/done handshake bundle between a datapath master and data_mem_unit.
// The master drives the request fields. The memory unit returns load data and status.
interface data_mem_unit_if;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        busy;
    logic        done;
    logic        err;

    modport master (
        output req, we, size, sign_ext, addr, wdata,
        input  rdata, busy, done, err
    );

    modport slave (
        input  req, we, size, sign_ext, addr, wdata,
        output rdata, busy, done, err
    );
endinterface

// File: rtl/data_mem_unit.sv
// Multi-cycle little-endian data memory with configurable wait states and a request/done handshake.
// Define DMEM_MISALIGN_TRAP_EN to make misaligned accesses complete with an err pulse instead of executing.
module data_mem_unit #(
    parameter int DEPTH_LOG2 = 8,
    parameter int LATENCY    = 2
) (
    input  logic clk,
    input  logic rst,
    data_mem_unit_if.slave bus
);

    typedef enum logic [1:0] {IDLE, WAIT, ACCESS} state_t;

    localparam int         AW        = DEPTH_LOG2 + 2;
    localparam logic [3:0] WAIT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    logic [31:0] mem [0:(1 << DEPTH_LOG2) - 1];

    state_t      state;
    logic [3:0]  cnt;
    logic        we_q;
    logic [1:0]  size_q;
    logic        sign_q;
    logic [AW-1:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        busy_q;
    logic        done_q;

    logic [DEPTH_LOG2-1:0] idx;
    logic [31:0] word_rd;
    logic [7:0]  byte_val;
    logic [15:0] half_val;
    logic [31:0] load_val;
    logic [3:0]  be;
    logic [31:0] wlane;
    logic        is_word;
    logic        is_half;
    logic        misalign;

    // Address bits above the array size are deliberately ignored so accesses wrap.
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.addr[31:AW];

    // Lane selection, load extension and store byte enables all derive from the latched request.
    always_comb begin
        idx      = addr_q[AW-1:2];
        word_rd  = mem[idx];
        is_word  = size_q[1];
        is_half  = (size_q == 2'b01);
`ifdef DMEM_MISALIGN_TRAP_EN
        misalign = (is_half && addr_q[0]) || (is_word && (addr_q[1:0] != 2'b00));
`else
        misalign = 1'b0;
`endif
        case (addr_q[1:0])
            2'b00:   byte_val = word_rd[7:0];
            2'b01:   byte_val = word_rd[15:8];
            2'b10:   byte_val = word_rd[23:16];
            default: byte_val = word_rd[31:24];
        endcase
        half_val = addr_q[1] ? word_rd[31:16] : word_rd[15:0];

        if (is_word) begin
            load_val = word_rd;
            be       = 4'b1111;
            wlane    = wdata_q;
        end else if (is_half) begin
            load_val = {{16{sign_q & half_val[15]}}, half_val};
            be       = addr_q[1] ? 4'b1100 : 4'b0011;
            wlane    = {2{wdata_q[15:0]}};
        end else begin
            load_val = {{24{sign_q & byte_val[7]}}, byte_val};
            be       = 4'b0001 << addr_q[1:0];
            wlane    = {4{wdata_q[7:0]}};
        end
    end

    // Array writes are gated by rst so a reset landing on the ACCESS edge still aborts the store.
    always_ff @(posedge clk) begin
        if (!rst && (state == ACCESS) && we_q && !misalign) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= wlane[8*i +: 8];
                end
            end
        end
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    logic err_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rdata_q <= 32'h0;
`ifdef DMEM_MISALIGN_TRAP_EN
            err_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
            err_q  <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (bus.req) begin
                        we_q    <= bus.we;
                        size_q  <= bus.size;
                        sign_q  <= bus.sign_ext;
                        addr_q  <= bus.addr[AW-1:0];
                        wdata_q <= bus.wdata;
                        busy_q  <= 1'b1;
                        if (LATENCY == 0) begin
                            state <= ACCESS;
                        end else begin
                            state <= WAIT;
                            cnt   <= WAIT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= ACCESS;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ACCESS: begin
                    done_q <= 1'b1;
`ifdef DMEM_MISALIGN_TRAP_EN
                    err_q  <= misalign;
`endif
                    if (!we_q && !misalign) begin
                        rdata_q <= load_val;
                    end
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.rdata = rdata_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
`ifdef DMEM_MISALIGN_TRAP_EN
    assign bus.err   = err_q;
`else
    assign bus.err   = 1'b0;
`endif

endmodule

// File: tb/tb_data_mem_unit.sv
// Directed bench for data_mem_unit at LATENCY=2: word/byte/half paths, partial stores,
// handshake corner cases, mid-access reset and misaligned word loads.
module tb_data_mem_unit;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   lat;
    int   busyCycles;
    int   doneCount;

    data_mem_unit_if bus ();

    data_mem_unit #(.DEPTH_LOG2(8), .LATENCY(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Called at a falling edge; returns at the falling edge of the done cycle (or after a timeout).
    task automatic applyStimulus(input logic w, input logic [1:0] sz, input logic sx,
                                 input logic [31:0] a, input logic [31:0] d,
                                 output int latOut, output int busyOut);
        bus.req      = 1'b1;
        bus.we       = w;
        bus.size     = sz;
        bus.sign_ext = sx;
        bus.addr     = a;
        bus.wdata    = d;
        @(posedge clk);
        #1 bus.req = 1'b0;
        latOut  = 0;
        busyOut = 0;
        @(negedge clk);
        while (!bus.done && latOut < 40) begin
            if (bus.busy) busyOut++;
            @(negedge clk);
            latOut++;
        end
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst          = 1'b1;
        bus.req      = 1'b0;
        bus.we       = 1'b0;
        bus.size     = 2'b10;
        bus.sign_ext = 1'b0;
        bus.addr     = 32'h0;
        bus.wdata    = 32'h0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_busy",  {31'h0, bus.busy}, 32'h0);
        checkOutput("reset_done",  {31'h0, bus.done}, 32'h0);
        checkOutput("reset_err",   {31'h0, bus.err},  32'h0);
        checkOutput("reset_rdata", bus.rdata,         32'h0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] word store and load");
        applyStimulus(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, lat, busyCycles);
        checkOutput("st_word_lat",  lat,        32'd3);
        checkOutput("st_word_busy", busyCycles, 32'd3);
        checkOutput("st_rdata_kept", bus.rdata, 32'h0);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, busyCycles);
        checkOutput("ld_word_lat",   lat,        32'd3);
        checkOutput("ld_word_busy",  busyCycles, 32'd3);
        checkOutput("ld_word_rdata", bus.rdata,  32'hDEADBEEF);
        checkOutput("ld_word_err",   {31'h0, bus.err}, 32'h0);

        $display("[TB] load extension");
        applyStimulus(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, lat, busyCycles);
        checkOutput("ld_byte_sx",  bus.rdata, 32'hFFFFFFDE);
        applyStimulus(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, lat, busyCycles);
        checkOutput("ld_byte_zx",  bus.rdata, 32'h000000DE);
        applyStimulus(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, lat, busyCycles);
        checkOutput("ld_half_sx",  bus.rdata, 32'hFFFFDEAD);
        applyStimulus(1'b0, 2'b01, 1'b0, 32'h10, 32'h0, lat, busyCycles);
        checkOutput("ld_half_zx",  bus.rdata, 32'h0000BEEF);
        applyStimulus(1'b0, 2'b00, 1'b1, 32'h10, 32'h0, lat, busyCycles);
        checkOutput("ld_byte0_sx", bus.rdata, 32'hFFFFFFEF);

        $display("[TB] partial stores");
        applyStimulus(1'b1, 2'b00, 1'b0, 32'h11, 32'hAAAAAA55, lat, busyCycles);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, busyCycles);
        checkOutput("st_byte_merge", bus.rdata, 32'hDEAD55EF);
        applyStimulus(1'b1, 2'b01, 1'b0, 32'h22, 32'h00001234, lat, busyCycles);
        applyStimulus(1'b1, 2'b01, 1'b0, 32'h20, 32'h0000ABCD, lat, busyCycles);
        applyStimulus(1'b0, 2'b11, 1'b0, 32'h420, 32'h0, lat, busyCycles);
        checkOutput("st_half_wrap_size3", bus.rdata, 32'h1234ABCD);

        $display("[TB] req held while busy");
        bus.req  = 1'b1;
        bus.we   = 1'b0;
        bus.size = 2'b10;
        bus.addr = 32'h10;
        doneCount = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.done) doneCount++;
        end
        bus.req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.done) doneCount++;
        end
        checkOutput("held_req_one_done", doneCount, 32'd1);
        checkOutput("held_req_idle", {31'h0, bus.busy}, 32'h0);

        $display("[TB] back-to-back in done cycle");
        applyStimulus(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, lat, busyCycles);
        checkOutput("b2b_first_rdata", bus.rdata, 32'h000000EF);
        applyStimulus(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, lat, busyCycles);
        checkOutput("b2b_second_lat",   lat,       32'd3);
        checkOutput("b2b_second_rdata", bus.rdata, 32'h00000055);

        $display("[TB] reset during store wait");
        bus.req   = 1'b1;
        bus.we    = 1'b1;
        bus.size  = 2'b10;
        bus.addr  = 32'h10;
        bus.wdata = 32'h12345678;
        @(posedge clk);
        #1 bus.req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort_busy", {31'h0, bus.busy}, 32'h0);
        doneCount = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.done) doneCount++;
        end
        checkOutput("abort_no_done", doneCount, 32'd0);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, busyCycles);
        checkOutput("abort_no_write", bus.rdata, 32'hDEAD55EF);

        $display("[TB] misaligned word load");
        applyStimulus(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, lat, busyCycles);
        applyStimulus(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, lat, busyCycles);
        checkOutput("pre_misalign_rdata", bus.rdata, 32'h000000DE);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h12, 32'h0, lat, busyCycles);
        checkOutput("misalign_lat",  lat, 32'd3);
        checkOutput("misalign_done", {31'h0, bus.done}, 32'h1);
`ifdef DMEM_MISALIGN_TRAP_EN
        checkOutput("misalign_err",   {31'h0, bus.err}, 32'h1);
        checkOutput("misalign_rdata", bus.rdata,        32'h000000DE);
        @(negedge clk);
        checkOutput("misalign_err_pulse", {31'h0, bus.err}, 32'h0);
`else
        checkOutput("misalign_err",   {31'h0, bus.err}, 32'h0);
        checkOutput("misalign_rdata", bus.rdata,        32'hDEADBEEF);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
